// File: rtl/if_fetch_unit_if.sv
// ============================================================================
// Module   : if_fetch_unit_if
// Desc     : Bundle of the instruction-memory, redirect and decode handshake
//            signals around the fetch stage. The master modport is the fetch
//            unit itself; the slave modport is its environment.
// Options  : IF_MISALIGN_EXC_EN - adds the id_misaligned flag toward decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if #(
    parameter int NB_ADDR = 32,
    parameter int NB_WORD = 32
);
    logic [NB_ADDR-1:0] imem_pc;
    logic [NB_WORD-1:0] imem_instruction;
    logic               redirect_valid;
    logic [NB_ADDR-1:0] redirect_pc;
    logic               id_valid;
    logic               id_ready;
    logic [NB_WORD-1:0] id_instr;
    logic [NB_ADDR-1:0] id_pc;
    logic [NB_ADDR-1:0] id_pc_plus4;
`ifdef IF_MISALIGN_EXC_EN
    logic               id_misaligned;

    modport master (
        output imem_pc, id_valid, id_instr, id_pc, id_pc_plus4, id_misaligned,
        input  imem_instruction, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_pc, id_valid, id_instr, id_pc, id_pc_plus4, id_misaligned,
        output imem_instruction, redirect_valid, redirect_pc, id_ready
    );
`else
    modport master (
        output imem_pc, id_valid, id_instr, id_pc, id_pc_plus4,
        input  imem_instruction, redirect_valid, redirect_pc, id_ready
    );
    modport slave (
        input  imem_pc, id_valid, id_instr, id_pc, id_pc_plus4,
        output imem_instruction, redirect_valid, redirect_pc, id_ready
    );
`endif
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// Module   : if_fetch_unit
// Desc     : Instruction fetch stage. Issues one sequential read per cycle to
//            a 1-cycle-latency instruction memory, buffers returned
//            {pc, instr} pairs in a small FIFO and hands them to decode over
//            valid/ready. A redirect flushes the buffer, drops the in-flight
//            read and restarts fetching at the target.
// Options  : IF_MISALIGN_EXC_EN - report a per-entry misaligned flag to
//            decode; when undefined, redirect targets are forced to a word
//            boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit #(
    parameter int                 NB_ADDR    = 32,
    parameter int                 NB_WORD    = 32,
    parameter logic [NB_ADDR-1:0] RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  wire             clk,
    input  wire             rst_n,
    if_fetch_unit_if.master bus
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int                 c_OCC_W   = c_CNT_W + 1;
    localparam logic [NB_ADDR-1:0] c_PC_STEP = NB_ADDR'(4);

    logic [NB_ADDR-1:0] r_fetch_pc;
    logic               r_inflight;
    logic [NB_ADDR-1:0] r_inflight_pc;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [NB_ADDR-1:0] r_pc_mem    [FIFO_DEPTH];
    logic [NB_WORD-1:0] r_instr_mem [FIFO_DEPTH];

    logic               w_head_valid;
    logic               w_flush;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_OCC_W-1:0] w_occ;
    logic [NB_ADDR-1:0] w_redir_pc;

`ifdef IF_MISALIGN_EXC_EN
    // Misaligned targets are fetched as-is; decode raises the exception.
    assign w_redir_pc = bus.redirect_pc;
`else
    assign w_redir_pc = {bus.redirect_pc[NB_ADDR-1:2], 2'b00};
    wire w_unused_redir_lsb = ^bus.redirect_pc[1:0];
`endif

    assign w_head_valid = (r_count != '0);
    assign w_flush      = bus.redirect_valid;
    assign w_pop        = w_head_valid && bus.id_ready;
    // A return that lands in the same cycle as a redirect belongs to the old stream.
    assign w_push       = r_inflight && !w_flush;

    // Occupancy once this cycle's pop is retired; the read in flight already owns a slot.
    assign w_occ   = c_OCC_W'(r_count) + c_OCC_W'(r_inflight) - c_OCC_W'(w_pop);
    assign w_issue = !w_flush && (w_occ < c_OCC_W'(FIFO_DEPTH));

    // Fetch PC, in-flight tracking and FIFO bookkeeping; reset beats redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (w_flush) begin
            r_fetch_pc <= w_redir_pc;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + c_PC_STEP;
            end
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; only slots covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_pc_mem[r_tail]    <= r_inflight_pc;
            r_instr_mem[r_tail] <= bus.imem_instruction;
        end
    end

    assign bus.imem_pc     = r_fetch_pc;
    assign bus.id_valid    = w_head_valid;
    // Head fields read as zero while the buffer is empty, so reset leaves them at 0.
    assign bus.id_pc       = w_head_valid ? r_pc_mem[r_head] : '0;
    assign bus.id_instr    = w_head_valid ? r_instr_mem[r_head] : '0;
    assign bus.id_pc_plus4 = w_head_valid ? (r_pc_mem[r_head] + c_PC_STEP) : '0;
`ifdef IF_MISALIGN_EXC_EN
    assign bus.id_misaligned = w_head_valid && (r_pc_mem[r_head][1:0] != 2'b00);
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// Module   : tb_if_fetch_unit
// Desc     : Self-checking bench for if_fetch_unit: a cycle table of directed
//            scenarios followed by a randomized run checked against a
//            stream-level reference model.
// Options  : IF_MISALIGN_EXC_EN - also checks id_misaligned.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

    localparam int          c_DEPTH = 2;
    localparam logic [31:0] c_KEY   = 32'hC0DE_0000;
`ifdef IF_MISALIGN_EXC_EN
    localparam logic [31:0] c_MASK  = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_MASK  = 32'hFFFF_FFFC;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if #(.NB_ADDR(32), .NB_WORD(32)) bus ();

    if_fetch_unit #(
        .NB_ADDR    (32),
        .NB_WORD    (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ c_KEY;
    endfunction

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk) bus.imem_instruction <= mem_word(bus.imem_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_imem;
        logic        zchk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eimem,
                       input logic z);
        vec_t v;
        v.rst_n = rs; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_imem = eimem; v.zchk = z;
        vecs.push_back(v);
    endtask

    task automatic build_vectors();
        logic [31:0] m;
        m = 32'h0000_0102 & c_MASK;
        // reset state, then first fetches with decode ready
        add(0, 0, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 0);
        add(1, 0, 0, 1,  0, 0, 32'h4, 0);
        // decode stalls for 5 cycles on the first valid entry
        for (int k = 0; k < 5; k++) add(1, 0, 0, 0,  1, 32'h0, 32'h8, 0);
        add(1, 0, 0, 1,  1, 32'h0, 32'h8, 0);
        add(1, 0, 0, 1,  1, 32'h4, 32'hC, 0);
        add(1, 0, 0, 1,  1, 32'h8, 32'h10, 0);
        add(1, 0, 0, 1,  1, 32'hC, 32'h14, 0);
        // redirect while an entry is buffered and 0x14 is in flight
        add(1, 1, 32'h100, 0,  1, 32'h10, 32'h18, 0);
        add(1, 0, 0, 1,  0, 0, 32'h100, 0);
        add(1, 0, 0, 1,  0, 0, 32'h104, 0);
        add(1, 0, 0, 1,  1, 32'h100, 32'h108, 0);
        // back-to-back redirects, the second one wins
        add(1, 1, 32'h200, 1,  1, 32'h104, 32'h10C, 0);
        add(1, 1, 32'h300, 1,  0, 0, 32'h200, 0);
        add(1, 0, 0, 1,  0, 0, 32'h300, 0);
        add(1, 0, 0, 1,  0, 0, 32'h304, 0);
        add(1, 0, 0, 1,  1, 32'h300, 32'h308, 0);
        add(1, 0, 0, 1,  1, 32'h304, 32'h30C, 0);
        // address wrap at the top of the space
        add(1, 1, 32'hFFFF_FFF8, 1,  1, 32'h308, 32'h310, 0);
        add(1, 0, 0, 1,  0, 0, 32'hFFFF_FFF8, 0);
        add(1, 0, 0, 1,  0, 0, 32'hFFFF_FFFC, 0);
        add(1, 0, 0, 1,  1, 32'hFFFF_FFF8, 32'h0, 0);
        add(1, 0, 0, 1,  1, 32'hFFFF_FFFC, 32'h4, 0);
        add(1, 0, 0, 1,  1, 32'h0, 32'h8, 0);
        // misaligned redirect target
        add(1, 1, 32'h102, 1,  1, 32'h4, 32'hC, 0);
        add(1, 0, 0, 1,  0, 0, m, 0);
        add(1, 0, 0, 1,  0, 0, m + 32'h4, 0);
        add(1, 0, 0, 1,  1, m, m + 32'h8, 0);
        add(1, 0, 0, 1,  1, m + 32'h4, m + 32'hC, 0);
        // reset together with a redirect: reset wins, stream restarts at 0
        add(0, 1, 32'h500, 1,  1, m + 32'h8, m + 32'h10, 0);
        add(0, 0, 0, 1,  0, 0, 0, 1);
        add(1, 0, 0, 1,  0, 0, 0, 0);
        add(1, 0, 0, 1,  0, 0, 32'h4, 0);
        add(1, 0, 0, 1,  1, 32'h0, 32'h8, 0);
        add(1, 0, 0, 1,  1, 32'h4, 32'hC, 0);
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("vec%0d_valid", i), 32'(bus.id_valid), 32'(v.e_valid));
        chk($sformatf("vec%0d_imem_pc", i), bus.imem_pc, v.e_imem);
        if (v.e_valid) begin
            chk($sformatf("vec%0d_pc", i), bus.id_pc, v.e_pc);
            chk($sformatf("vec%0d_instr", i), bus.id_instr, mem_word(v.e_pc));
            chk($sformatf("vec%0d_pc_plus4", i), bus.id_pc_plus4, v.e_pc + 32'h4);
`ifdef IF_MISALIGN_EXC_EN
            chk($sformatf("vec%0d_misaligned", i), 32'(bus.id_misaligned),
                32'(v.e_pc[1:0] != 2'b00));
`endif
        end
        if (v.zchk) begin
            chk($sformatf("vec%0d_rst_pc", i), bus.id_pc, 32'h0);
            chk($sformatf("vec%0d_rst_instr", i), bus.id_instr, 32'h0);
            chk($sformatf("vec%0d_rst_pc_plus4", i), bus.id_pc_plus4, 32'h0);
        end
    endtask

    // Stream model: decode must see consecutive words from the latest
    // restart point, valid from the third cycle after a restart onward.
    task automatic run_random(input int cycles);
        logic [31:0] m_next;
        int          m_wait;
        logic        m_zero;
        logic        m_imem_chk;
        logic [31:0] m_imem_exp;
        logic        pop;

        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        @(posedge clk); #1;
        m_next = 32'h0; m_wait = 2; m_zero = 1'b1;
        m_imem_chk = 1'b1; m_imem_exp = 32'h0;

        for (int c = 0; c < cycles; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ?
                              (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            bus.id_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);

            chk($sformatf("rnd%0d_valid", c), 32'(bus.id_valid), 32'(m_wait == 0));
            if (m_wait == 0) begin
                chk($sformatf("rnd%0d_pc", c), bus.id_pc, m_next);
                chk($sformatf("rnd%0d_instr", c), bus.id_instr, mem_word(m_next));
                chk($sformatf("rnd%0d_pc_plus4", c), bus.id_pc_plus4, m_next + 32'h4);
`ifdef IF_MISALIGN_EXC_EN
                chk($sformatf("rnd%0d_misaligned", c), 32'(bus.id_misaligned),
                    32'(m_next[1:0] != 2'b00));
`endif
            end
            if (m_zero) begin
                chk($sformatf("rnd%0d_rst_pc", c), bus.id_pc, 32'h0);
                chk($sformatf("rnd%0d_rst_instr", c), bus.id_instr, 32'h0);
            end
            if (m_imem_chk) begin
                chk($sformatf("rnd%0d_imem_pc", c), bus.imem_pc, m_imem_exp);
            end
            chk($sformatf("rnd%0d_fifo_bound", c), 32'(dut.r_count <= c_DEPTH), 32'h1);

            pop = (m_wait == 0) && bus.id_ready;
            if (!rst_n) begin
                m_next = 32'h0; m_wait = 2; m_zero = 1'b1;
                m_imem_chk = 1'b1; m_imem_exp = 32'h0;
            end else if (bus.redirect_valid) begin
                m_next = bus.redirect_pc & c_MASK; m_wait = 2; m_zero = 1'b0;
                m_imem_chk = 1'b1; m_imem_exp = m_next;
            end else begin
                if (pop) m_next = m_next + 32'h4;
                if (m_wait > 0) m_wait--;
                m_zero = 1'b0;
                m_imem_chk = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b0;
        build_vectors();
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc = vecs[i].rpc;
            bus.id_ready = vecs[i].rdy;
            @(negedge clk);
            check_vec(i, vecs[i]);
            @(posedge clk); #1;
        end
        run_random(4000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
